// File: rtl/frame_serialize.sv
// Frame serializer: emits a 4-byte height/width header followed by R,G,B bytes per pixel.
// Pixel input and byte output both use valid/ready handshakes; every output is registered.
module frame_serialize #(
    parameter int DIM_W  = 16,
    parameter int PCNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [DIM_W-1:0] height_in,
    input  logic [DIM_W-1:0] width_in,
    input  logic [7:0]       pix_r,
    input  logic [7:0]       pix_g,
    input  logic [7:0]       pix_b,
    input  logic             pix_valid,
    output logic             pix_ready,
    output logic [7:0]       data_out,
    output logic             data_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             frame_done
);

    // state   | meaning
    // IDLE    | waiting for start
    // HDR     | sending header byte hdr_idx (h hi, h lo, w hi, w lo)
    // FETCH   | requesting the next pixel from the source
    // SEND_R  | sending red byte of the held pixel
    // SEND_G  | sending green byte of the held pixel
    // SEND_B  | sending blue byte; advances the pixel count on transfer
    // DONE    | one-cycle frame_done pulse
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_HDR    = 3'd1;
    localparam logic [2:0] S_FETCH  = 3'd2;
    localparam logic [2:0] S_SEND_R = 3'd3;
    localparam logic [2:0] S_SEND_G = 3'd4;
    localparam logic [2:0] S_SEND_B = 3'd5;
    localparam logic [2:0] S_DONE   = 3'd6;

    logic [2:0]        state_q,   state_d;
    logic [1:0]        hdr_idx_q, hdr_idx_d;
    logic [PCNT_W-1:0] pix_cnt_q, pix_cnt_d;
    logic [PCNT_W-1:0] total_q,   total_d;
    logic [DIM_W-1:0]  height_q,  height_d;
    logic [DIM_W-1:0]  width_q,   width_d;
    logic [7:0]        r_q, r_d, g_q, g_d, b_q, b_d;

    logic [7:0]        data_out_q,   data_out_d;
    logic              data_valid_q, data_valid_d;
    logic              pix_ready_q,  pix_ready_d;
    logic              busy_q,       busy_d;
    logic              frame_done_q, frame_done_d;

    logic                byte_xfer;
    logic                pix_xfer;
    logic [2*DIM_W-1:0]  dim_prod;
    logic [PCNT_W-1:0]   pix_cnt_inc;
    logic [15:0]         h16;
    logic [15:0]         w16;

    assign byte_xfer   = data_valid_q & out_ready;
    assign pix_xfer    = pix_ready_q & pix_valid;
    assign dim_prod    = {{DIM_W{1'b0}}, height_in} * {{DIM_W{1'b0}}, width_in};
    assign pix_cnt_inc = pix_cnt_q + PCNT_W'(1);

    always_comb begin
        state_d   = state_q;
        hdr_idx_d = hdr_idx_q;
        pix_cnt_d = pix_cnt_q;
        total_d   = total_q;
        height_d  = height_q;
        width_d   = width_q;
        r_d       = r_q;
        g_d       = g_q;
        b_d       = b_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    height_d  = height_in;
                    width_d   = width_in;
                    total_d   = PCNT_W'(dim_prod);
                    hdr_idx_d = 2'd0;
                    pix_cnt_d = '0;
                    state_d   = S_HDR;
                end
            end
            S_HDR: begin
                if (byte_xfer) begin
                    hdr_idx_d = hdr_idx_q + 2'd1;
                    if (hdr_idx_q == 2'd3) begin
                        state_d = (total_q != '0) ? S_FETCH : S_DONE;
                    end
                end
            end
            S_FETCH: begin
                if (pix_xfer) begin
                    r_d     = pix_r;
                    g_d     = pix_g;
                    b_d     = pix_b;
                    state_d = S_SEND_R;
                end
            end
            S_SEND_R: if (byte_xfer) state_d = S_SEND_G;
            S_SEND_G: if (byte_xfer) state_d = S_SEND_B;
            S_SEND_B: begin
                if (byte_xfer) begin
                    pix_cnt_d = pix_cnt_inc;
                    state_d   = (pix_cnt_inc == total_q) ? S_DONE : S_FETCH;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they come straight out of flops.
    always_comb begin
        h16          = 16'(height_d);
        w16          = 16'(width_d);
        data_out_d   = 8'h00;
        data_valid_d = 1'b0;
        pix_ready_d  = (state_d == S_FETCH);
        busy_d       = (state_d != S_IDLE);
        frame_done_d = (state_d == S_DONE);
        case (state_d)
            S_HDR: begin
                data_valid_d = 1'b1;
                case (hdr_idx_d)
                    2'd0:    data_out_d = h16[15:8];
                    2'd1:    data_out_d = h16[7:0];
                    2'd2:    data_out_d = w16[15:8];
                    default: data_out_d = w16[7:0];
                endcase
            end
            S_SEND_R: begin
                data_valid_d = 1'b1;
                data_out_d   = r_d;
            end
            S_SEND_G: begin
                data_valid_d = 1'b1;
                data_out_d   = g_d;
            end
            S_SEND_B: begin
                data_valid_d = 1'b1;
                data_out_d   = b_d;
            end
            default: begin
                data_valid_d = 1'b0;
                data_out_d   = 8'h00;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            hdr_idx_q    <= 2'd0;
            pix_cnt_q    <= '0;
            total_q      <= '0;
            height_q     <= '0;
            width_q      <= '0;
            r_q          <= 8'h00;
            g_q          <= 8'h00;
            b_q          <= 8'h00;
            data_out_q   <= 8'h00;
            data_valid_q <= 1'b0;
            pix_ready_q  <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            hdr_idx_q    <= hdr_idx_d;
            pix_cnt_q    <= pix_cnt_d;
            total_q      <= total_d;
            height_q     <= height_d;
            width_q      <= width_d;
            r_q          <= r_d;
            g_q          <= g_d;
            b_q          <= b_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            pix_ready_q  <= pix_ready_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign pix_ready  = pix_ready_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

endmodule
